// File: rtl/generation_scheduler.sv
// Generation sequencer for the ping-pong Game-of-Life banks: issues toroidal row fetches, tracks returned row writes, swaps banks.
// Optional GEN_SCHED_FRAME_SYNC_EN: when defined, the bank swap waits for frame_start; otherwise it swaps one cycle after the final write.
module generation_scheduler #(
    parameter int Y_SIZE    = 720,
    parameter int Y_WIDTH   = 10,
    parameter int GEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pause_req,
    input  logic                 step_req,
    input  logic                 frame_start,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [Y_WIDTH-1:0]   line_buffer_fetch_addr,
    input  logic                 parallel_next_state_write_en,
    input  logic [Y_WIDTH-1:0]   parallel_next_state_write_addr,
    output logic                 mode,
    output logic [GEN_WIDTH-1:0] gen_count,
    output logic                 gen_done,
    output logic                 busy,
    output logic                 seq_err
);

    localparam int CNT_W = $clog2(Y_SIZE + 2);
    localparam logic [Y_WIDTH-1:0] LAST_ROW   = Y_WIDTH'(Y_SIZE - 1);
    localparam logic [CNT_W-1:0]   LAST_FETCH = CNT_W'(Y_SIZE + 1);

    typedef enum logic [1:0] {
        PAUSED,
        RUN,
        DRAIN,
        WAIT_SWAP
    } state_e;

    state_e                 state_q;
    logic                   fetch_valid_q;
    logic [Y_WIDTH-1:0]     fetch_addr_q;
    logic [Y_WIDTH-1:0]     fetch_addr_d;
    logic [CNT_W-1:0]       fetch_cnt_q;
    logic [Y_WIDTH-1:0]     exp_row_q;
    logic                   step_q;
    logic                   mode_q;
    logic [GEN_WIDTH-1:0]   gen_count_q;
    logic                   gen_done_q;
    logic                   busy_q;
    logic                   seq_err_q;
    logic                   swap_go;

    // Row wrap is by compare so non-power-of-2 grid heights work.
    always_comb begin
        fetch_addr_d = (fetch_addr_q == LAST_ROW) ? '0 : fetch_addr_q + 1'b1;
    end

`ifdef GEN_SCHED_FRAME_SYNC_EN
    always_comb begin
        swap_go = frame_start;
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    always_comb begin
        swap_go = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PAUSED;
            fetch_valid_q <= 1'b0;
            fetch_addr_q  <= LAST_ROW;
            fetch_cnt_q   <= '0;
            exp_row_q     <= '0;
            step_q        <= 1'b0;
            mode_q        <= 1'b0;
            gen_count_q   <= '0;
            gen_done_q    <= 1'b0;
            busy_q        <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            gen_done_q <= 1'b0;
            case (state_q)
                PAUSED: begin
                    if (parallel_next_state_write_en) begin
                        seq_err_q <= 1'b1;
                    end
                    // fetch_valid rises one cycle after leaving PAUSED
                    if (!pause_req || step_req) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        step_q       <= step_req;
                        fetch_addr_q <= LAST_ROW;
                        fetch_cnt_q  <= '0;
                        exp_row_q    <= '0;
                    end
                end
                RUN: begin
                    if (!fetch_valid_q) begin
                        fetch_valid_q <= 1'b1;
                    end else if (fetch_ready) begin
                        if (fetch_cnt_q == LAST_FETCH) begin
                            state_q       <= DRAIN;
                            fetch_valid_q <= 1'b0;
                        end else begin
                            fetch_cnt_q  <= fetch_cnt_q + 1'b1;
                            fetch_addr_q <= fetch_addr_d;
                        end
                    end
                end
                DRAIN: begin
                end
                WAIT_SWAP: begin
                    if (parallel_next_state_write_en) begin
                        seq_err_q <= 1'b1;
                    end
                    if (swap_go) begin
                        mode_q      <= ~mode_q;
                        gen_count_q <= gen_count_q + 1'b1;
                        gen_done_q  <= 1'b1;
                        step_q      <= 1'b0;
                        if (step_q || pause_req) begin
                            state_q <= PAUSED;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q       <= RUN;
                            fetch_valid_q <= 1'b1;
                            fetch_addr_q  <= LAST_ROW;
                            fetch_cnt_q   <= '0;
                            exp_row_q     <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= PAUSED;
                end
            endcase

            // The final row write ends the generation even if fetches are still outstanding.
            if ((state_q == RUN || state_q == DRAIN) && parallel_next_state_write_en) begin
                if (parallel_next_state_write_addr != exp_row_q) begin
                    seq_err_q <= 1'b1;
                end
                if (exp_row_q == LAST_ROW) begin
                    state_q       <= WAIT_SWAP;
                    fetch_valid_q <= 1'b0;
                    exp_row_q     <= '0;
                end else begin
                    exp_row_q <= exp_row_q + 1'b1;
                end
            end
        end
    end

    assign fetch_valid            = fetch_valid_q;
    assign line_buffer_fetch_addr = fetch_addr_q;
    assign mode                   = mode_q;
    assign gen_count              = gen_count_q;
    assign gen_done               = gen_done_q;
    assign busy                   = busy_q;
    assign seq_err                = seq_err_q;

endmodule

// File: tb/tb_generation_scheduler.sv
// Directed testbench for generation_scheduler with an 8-row grid; expectations follow GEN_SCHED_FRAME_SYNC_EN when defined.
module tb_generation_scheduler;

    localparam int Y_SIZE    = 8;
    localparam int Y_WIDTH   = 4;
    localparam int GEN_WIDTH = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 pause_req;
    logic                 step_req;
    logic                 frame_start;
    logic                 fetch_valid;
    logic                 fetch_ready;
    logic [Y_WIDTH-1:0]   line_buffer_fetch_addr;
    logic                 write_en;
    logic [Y_WIDTH-1:0]   write_addr;
    logic                 mode;
    logic [GEN_WIDTH-1:0] gen_count;
    logic                 gen_done;
    logic                 busy;
    logic                 seq_err;

    int checkCount = 0;
    int failCount  = 0;

    generation_scheduler #(
        .Y_SIZE(Y_SIZE),
        .Y_WIDTH(Y_WIDTH),
        .GEN_WIDTH(GEN_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pause_req(pause_req),
        .step_req(step_req),
        .frame_start(frame_start),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .line_buffer_fetch_addr(line_buffer_fetch_addr),
        .parallel_next_state_write_en(write_en),
        .parallel_next_state_write_addr(write_addr),
        .mode(mode),
        .gen_count(gen_count),
        .gen_done(gen_done),
        .busy(busy),
        .seq_err(seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rstMode", mode, 0);
        checkOutput("rstGenCount", gen_count, 0);
        checkOutput("rstGenDone", gen_done, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFetchValid", fetch_valid, 0);
        checkOutput("rstFetchAddr", line_buffer_fetch_addr, Y_SIZE - 1);
        checkOutput("rstSeqErr", seq_err, 0);
    endtask

    // Toroidal fetch order: last row, then 0..Y_SIZE-1, then 0 again
    function automatic int expFetch(input int idx);
        return (idx == 0) ? Y_SIZE - 1 : (idx - 1) % Y_SIZE;
    endfunction

    task automatic applyStimulus(input bit toggleReady);
        int idx = 0;
        int cyc = 0;
        int pat = 0;
        while (idx < Y_SIZE + 2 && cyc < 200) begin
            fetch_ready = toggleReady ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'b1;
            pat++;
            if (idx > 0) checkOutput("fetchValidHeld", fetch_valid, 1);
            if (fetch_valid) begin
                checkOutput("fetchAddr", line_buffer_fetch_addr, expFetch(idx));
                if (fetch_ready) idx++;
            end
            tick();
            cyc++;
        end
        fetch_ready = 1'b0;
        checkOutput("fetchCount", idx, Y_SIZE + 2);
        checkOutput("drainValid", fetch_valid, 0);
        checkOutput("drainBusy", busy, 1);
    endtask

    task automatic writeRows(input int skipAt, input bit frameOnLast);
        for (int r = 0; r < Y_SIZE; r++) begin
            write_en    = 1'b1;
            write_addr  = Y_WIDTH'((r >= skipAt) ? r + 1 : r);
            frame_start = frameOnLast && (r == Y_SIZE - 1);
            tick();
        end
        write_en    = 1'b0;
        write_addr  = '0;
        frame_start = 1'b0;
    endtask

    task automatic swapNow();
`ifdef GEN_SCHED_FRAME_SYNC_EN
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
`else
        tick();
`endif
    endtask

    initial begin
        rst_n = 1'b0; pause_req = 1'b0; step_req = 1'b0; frame_start = 1'b0;
        fetch_ready = 1'b0; write_en = 1'b0; write_addr = '0;
        tick();
        tick();
        checkResetValues();

        $display("[TB] free-running generation");
        rst_n = 1'b1;
        tick();
        checkOutput("startValidEdge1", fetch_valid, 0);
        checkOutput("startBusy", busy, 1);
        tick();
        checkOutput("startValidEdge2", fetch_valid, 1);
        applyStimulus(1'b0);
        writeRows(Y_SIZE, 1'b0);
        checkOutput("waitSwapMode", mode, 0);
`ifdef GEN_SCHED_FRAME_SYNC_EN
        repeat (3) tick();
        checkOutput("noFrameMode", mode, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
`else
        tick();
`endif
        checkOutput("swap1Mode", mode, 1);
        checkOutput("swap1GenCount", gen_count, 1);
        checkOutput("swap1GenDone", gen_done, 1);
        checkOutput("swap1FetchValid", fetch_valid, 1);
        checkOutput("swap1FetchAddr", line_buffer_fetch_addr, Y_SIZE - 1);
        checkOutput("swap1SeqErr", seq_err, 0);
        tick();
        checkOutput("genDoneOnePulse", gen_done, 0);
        checkOutput("addrHeldNotReady", line_buffer_fetch_addr, Y_SIZE - 1);

        $display("[TB] frame_start during RUN, ready toggling, pause at boundary");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checkOutput("runFrameMode", mode, 1);
        checkOutput("runFrameGenCount", gen_count, 1);
        pause_req = 1'b1;
        applyStimulus(1'b1);
        writeRows(Y_SIZE, 1'b1);
`ifdef GEN_SCHED_FRAME_SYNC_EN
        repeat (20) tick();
        checkOutput("lateFrameMode", mode, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
`else
        tick();
`endif
        checkOutput("swap2Mode", mode, 0);
        checkOutput("swap2GenCount", gen_count, 2);
        checkOutput("swap2Busy", busy, 0);
        checkOutput("swap2FetchValid", fetch_valid, 0);
        repeat (5) tick();
        checkOutput("pausedBusy", busy, 0);
        checkOutput("pausedGenCount", gen_count, 2);

        $display("[TB] single step");
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        checkOutput("stepBusy", busy, 1);
        applyStimulus(1'b0);
        writeRows(Y_SIZE, 1'b0);
        swapNow();
        checkOutput("step1GenCount", gen_count, 3);
        checkOutput("step1Busy", busy, 0);
        checkOutput("step1Mode", mode, 1);
        checkOutput("step1FetchValid", fetch_valid, 0);

        $display("[TB] out-of-order writes");
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        applyStimulus(1'b0);
        writeRows(2, 1'b0);
        checkOutput("orderSeqErr", seq_err, 1);
        swapNow();
        checkOutput("step2GenCount", gen_count, 4);
        checkOutput("step2Busy", busy, 0);
        checkOutput("seqErrSticky", seq_err, 1);

        $display("[TB] reset, then write strobe while paused");
        rst_n = 1'b0;
        #1;
        checkResetValues();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("pausedAfterReset", busy, 0);
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        checkOutput("pausedWriteSeqErr", seq_err, 1);

        $display("[TB] reset mid-RUN");
        rst_n = 1'b0;
        tick();
        pause_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        fetch_ready = 1'b1;
        repeat (5) tick();
        checkOutput("midRunAddr", line_buffer_fetch_addr, 4);
        rst_n = 1'b0;
        #1;
        checkResetValues();
        fetch_ready = 1'b0;
        tick();
        checkResetValues();
        rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("restartValid", fetch_valid, 1);
        checkOutput("restartAddr", line_buffer_fetch_addr, Y_SIZE - 1);
        checkOutput("restartMode", mode, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
